disk: RTL and testbench
=======================

// Module: disk
// PURPOSE
// - UART-backed "disk" and debug port for the CPU. Sits on the CPU data bus as a 1024 x 32 word buffer.
// - Serial bytes received on RxD are packed into words and stored in the buffer.
// - A debug pulse serialises the current PC and IR out on TxD.
// - State and status outputs are exported for LEDs and the 7-segment display.
// PARAMETERS
// - CLKS_PER_BIT  868  clock cycles per UART bit (100 MHz / 115200 baud)
// - DEPTH_LOG2    10   buffer address width; buffer holds 2**DEPTH_LOG2 words
// PORTS
// - clk        in   1   single system clock; all logic on rising edge
// - rst_n      in   1   synchronous, active-low reset
// - RxD        in   1   UART receive line, idle high, 8N1
// - TxD        out  1   UART transmit line, idle high, 8N1
// - BUS        inout 32 CPU data bus; driven only while Memread=1, else 32'bz
// - Memread    in   1   CPU read strobe for buffer[Addrin]
// - Memwrite   in   1   CPU write strobe: buffer[Addrin] <= BUS
// - Addrin     in   10  CPU word address into the buffer
// - debug      in   1   level input; its rising edge starts a PC/IR dump
// - PC         in   32  CPU program counter, sampled at dump start
// - IR         in   32  CPU instruction register, sampled at dump start
// - Busy       out  1   TX dump in progress OR RX frame in progress
// - Rstate     out  10  RX word write pointer (next buffer address written by UART)
// - Tstate     out  16  {tx_fsm[3:0], byte_idx[3:0], last_tx_byte[7:0]}
// - TxD_busy   out  1   UART transmitter shifting a frame
// - TxD_start  out  1   1-cycle pulse when a byte is loaded into the transmitter
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge) forces these values:
//   - TxD=1, Busy=0, Rstate=0, Tstate=0, TxD_busy=0, TxD_start=0, BUS=z.
//   - Any in-progress RX frame or TX dump is aborted.
//   - Buffer contents are not cleared.
// - CPU read path: BUS = buffer[Addrin] combinationally while Memread=1.
//   - Buffer uses an async-read array. Memread has priority only for driving the bus.
// - CPU write path: on a clk edge with Memwrite=1, buffer[Addrin] <= BUS.
//   - If the RX packer writes the same address in the same cycle, the CPU write wins.
// - RX:
//   - Start bit is detected on a falling edge of a 2-flop-synchronised RxD.
//   - Data is sampled at mid-bit (CLKS_PER_BIT/2 after the edge), then every CLKS_PER_BIT, LSB first.
//   - Stop bit is checked. If stop=0 the byte is discarded and the FSM returns to idle.
//   - Good bytes are packed big-endian: the first byte goes to bits [31:24].
//   - On the 4th byte, buffer[Rstate] is written and Rstate increments. Rstate wraps 1023 -> 0.
// - Debug dump:
//   - A rising edge of debug (registered compare) while idle latches PC and IR.
//   - TX sends 8 bytes: PC[31:24] .. PC[7:0], then IR[31:24] .. IR[7:0].
//   - debug edges arriving during a dump are ignored; no queueing.
// - TX FSM states: IDLE(0) -> LOAD(1) -> WAIT(2) -> back to LOAD, or DONE(3) -> IDLE.
//   - LOAD pulses TxD_start for one cycle and updates Tstate[7:0] with the byte.
//   - WAIT holds until TxD_busy falls. byte_idx counts 0..7.
// - UART TX frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts CLKS_PER_BIT cycles.
//   - TxD_busy is high from the cycle after TxD_start through the end of the stop bit.
// - Busy = (tx_fsm != IDLE) | rx_in_frame. The CPU may still access the buffer while Busy=1.
// STRUCTURE
// - Shared package disk_pkg holds:
//   - tx_state_t enum: IDLE, LOAD, WAIT, DONE.
//   - CLKS_PER_BIT default value.
//   - WORD_W = 32 and BYTE_W = 8.
// - One sub-module, uart_tx:
//   - Ports: clk, rst_n, start, data[7:0], txd, busy.
//   - The RX FSM, byte packer, buffer array and dump FSM stay in disk.
// TESTING (CLKS_PER_BIT=16, 10 ns clock)
// - Reset:
//   - Stimulus: hold rst_n=0 for 3 cycles.
//   - Expect: TxD=1, Busy=0, Rstate=0, Tstate=0, and BUS=z with Memread=0.
// - Debug dump:
//   - Stimulus: PC=32'h0000_0040, IR=32'h2001_0005; pulse debug high for 2 cycles.
//   - Expect: exactly one dump; 8 TxD_start pulses; TxD carries 00 00 00 40 20 01 00 05.
//   - Expect: Busy returns to 0 after the 8th stop bit.
// - CPU write/read:
//   - Stimulus: Memwrite with Addrin=10'h005 and BUS=32'hDEAD_BEEF; then Memread at the same address.
//   - Expect: BUS reads 32'hDEAD_BEEF.
// - RX pack:
//   - Stimulus: serially send 12 34 56 78 on RxD.
//   - Expect: buffer[0]=32'h1234_5678 (read via Memread) and Rstate=1.
// - RX framing error:
//   - Stimulus: send a byte with stop bit 0.
//   - Expect: no buffer write; Rstate unchanged; the next good byte is received normally.
// - Reset mid-dump:
//   - Stimulus: assert rst_n=0 during byte 3 of a dump.
//   - Expect: TxD=1 next cycle, Tstate=0, no further TxD_start pulses.

Source files
------------

// File: rtl/disk_pkg.sv
// Shared types and constants for the UART-backed disk buffer and its debug dump port.
package disk_pkg;

   localparam int unsigned WORD_W           = 32;
   localparam int unsigned BYTE_W           = 8;
   localparam int unsigned CLKS_PER_BIT_DEF = 868;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: loads a byte on start and shifts start, data (LSB first) and stop bits.
module uart_tx
   import disk_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [BYTE_W-1:0] data,
   output logic              txd,
   output logic              busy
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic              r_busy;
   logic [BYTE_W+1:0] r_shift;
   logic [CntW-1:0]   r_cnt;
   logic [3:0]        r_bit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy  <= 1'b0;
         r_shift <= '1;
         r_cnt   <= '0;
         r_bit   <= '0;
      end else if (!r_busy) begin
         if (start) begin
            r_shift <= {1'b1, data, 1'b0};
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
         end
      end else if (r_cnt == CntW'(CLKS_PER_BIT - 1)) begin
         r_cnt <= '0;
         // Busy drops only once the stop bit has been on the line for a full bit time.
         if (r_bit == 4'(BYTE_W + 1)) begin
            r_busy <= 1'b0;
         end else begin
            r_shift <= {1'b1, r_shift[BYTE_W+1:1]};
            r_bit   <= r_bit + 4'd1;
         end
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign txd  = r_busy ? r_shift[0] : 1'b1;
   assign busy = r_busy;

endmodule

// File: rtl/disk.sv
// CPU-visible word buffer filled from a UART byte stream, plus a PC/IR dump on the UART TX line.
module disk
   import disk_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned DEPTH_LOG2   = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  RxD,
   output logic                  TxD,
   inout  tri   [WORD_W-1:0]     BUS,
   input  logic                  Memread,
   input  logic                  Memwrite,
   input  logic [DEPTH_LOG2-1:0] Addrin,
   input  logic                  debug,
   input  logic [WORD_W-1:0]     PC,
   input  logic [WORD_W-1:0]     IR,
   output logic                  Busy,
   output logic [DEPTH_LOG2-1:0] Rstate,
   output logic [15:0]           Tstate,
   output logic                  TxD_busy,
   output logic                  TxD_start
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [WORD_W-1:0] r_mem [Depth];

   // ---------------- RX ----------------
   rx_state_t             r_rx_state, w_rx_state_d;
   logic [1:0]            r_rx_sync;
   logic                  r_rx_prev;
   logic [CntW-1:0]       r_rx_cnt;
   logic [2:0]            r_rx_bit;
   logic [BYTE_W-1:0]     r_rx_byte;
   logic [WORD_W-9:0]     r_rx_word;
   logic [1:0]            r_rx_nbytes;
   logic [DEPTH_LOG2-1:0] r_rstate;
   logic                  w_rx_fall, w_rx_tick, w_rx_shift, w_rx_good, w_rx_we;
   logic [WORD_W-1:0]     w_rx_word;

   assign w_rx_fall = r_rx_prev & ~r_rx_sync[1];
   // The start bit is checked half a bit in, which aligns every later sample to mid-bit.
   assign w_rx_tick = (r_rx_state == RX_START) ? (r_rx_cnt == CntW'(CLKS_PER_BIT / 2 - 1))
                                               : (r_rx_cnt == CntW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) r_rx_state <= RX_IDLE;
      else        r_rx_state <= w_rx_state_d;
   end

   always_comb begin
      w_rx_state_d = r_rx_state;
      unique case (r_rx_state)
         RX_IDLE:  if (w_rx_fall) w_rx_state_d = RX_START;
         RX_START: if (w_rx_tick) w_rx_state_d = r_rx_sync[1] ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_state_d = RX_STOP;
         RX_STOP:  if (w_rx_tick) w_rx_state_d = RX_IDLE;
         default:  w_rx_state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      w_rx_shift = (r_rx_state == RX_DATA) && w_rx_tick;
      w_rx_good  = (r_rx_state == RX_STOP) && w_rx_tick && r_rx_sync[1];
      w_rx_we    = w_rx_good && (r_rx_nbytes == 2'd3);
      w_rx_word  = {r_rx_word, r_rx_byte};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rx_sync   <= 2'b11;
         r_rx_prev   <= 1'b1;
         r_rx_cnt    <= '0;
         r_rx_bit    <= '0;
         r_rx_byte   <= '0;
         r_rx_word   <= '0;
         r_rx_nbytes <= '0;
         r_rstate    <= '0;
      end else begin
         r_rx_sync <= {r_rx_sync[0], RxD};
         r_rx_prev <= r_rx_sync[1];
         if (r_rx_state == RX_IDLE || w_rx_tick) r_rx_cnt <= '0;
         else                                   r_rx_cnt <= r_rx_cnt + 1'b1;
         if (w_rx_shift) begin
            r_rx_bit  <= r_rx_bit + 3'd1;
            r_rx_byte <= {r_rx_sync[1], r_rx_byte[BYTE_W-1:1]};
         end
         if (w_rx_good) begin
            r_rx_word   <= w_rx_word[WORD_W-9:0];
            r_rx_nbytes <= r_rx_nbytes + 2'd1;
         end
         if (w_rx_we) r_rstate <= r_rstate + 1'b1;
      end
   end

   // Later assignment wins, so a CPU write to the same address overrides the RX packer.
   always_ff @(posedge clk) begin
      if (w_rx_we)  r_mem[r_rstate] <= w_rx_word;
      if (Memwrite) r_mem[Addrin]   <= BUS;
   end

   assign BUS = Memread ? r_mem[Addrin] : 'z;

   // ---------------- Debug dump TX ----------------
   tx_state_t           r_tx_state, w_tx_state_d;
   logic                r_dbg_prev;
   logic [2*WORD_W-1:0] r_dump;
   logic [3:0]          r_byte_idx;
   logic [BYTE_W-1:0]   r_last_byte;
   logic                w_dbg_rise;
   logic [BYTE_W-1:0]   w_tx_byte;

   assign w_dbg_rise = debug & ~r_dbg_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) r_tx_state <= IDLE;
      else        r_tx_state <= w_tx_state_d;
   end

   always_comb begin
      w_tx_state_d = r_tx_state;
      unique case (r_tx_state)
         IDLE:    if (w_dbg_rise) w_tx_state_d = LOAD;
         LOAD:    w_tx_state_d = WAIT;
         WAIT:    if (!TxD_busy) w_tx_state_d = (r_byte_idx == 4'd7) ? DONE : LOAD;
         DONE:    w_tx_state_d = IDLE;
         default: w_tx_state_d = IDLE;
      endcase
   end

   always_comb begin
      TxD_start = (r_tx_state == LOAD);
      w_tx_byte = r_dump[2*WORD_W-1 -: BYTE_W];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dbg_prev  <= 1'b0;
         r_dump      <= '0;
         r_byte_idx  <= '0;
         r_last_byte <= '0;
      end else begin
         r_dbg_prev <= debug;
         if (r_tx_state == IDLE && w_dbg_rise) begin
            r_dump     <= {PC, IR};
            r_byte_idx <= '0;
         end
         if (r_tx_state == LOAD) begin
            r_last_byte <= w_tx_byte;
            r_dump      <= {r_dump[2*WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
         end
         if (r_tx_state == WAIT && !TxD_busy && r_byte_idx != 4'd7) begin
            r_byte_idx <= r_byte_idx + 4'd1;
         end
      end
   end

   uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .start (TxD_start),
      .data  (w_tx_byte),
      .txd   (TxD),
      .busy  (TxD_busy)
   );

   assign Busy   = (r_tx_state != IDLE) | (r_rx_state != RX_IDLE);
   assign Rstate = r_rstate;
   assign Tstate = {2'b00, r_tx_state, r_byte_idx, r_last_byte};

endmodule

// File: tb/tb_disk.sv
// Bench for disk: UART frames decoded from TxD and buffer words are checked against scoreboards.
module tb_disk;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst_n, RxD, Memread, Memwrite, debug;
   logic [9:0]  Addrin;
   logic [31:0] PC, IR;
   logic        TxD, Busy, TxD_busy, TxD_start;
   logic [9:0]  Rstate;
   logic [15:0] Tstate;
   logic [31:0] drv_val;
   logic        drv_en;
   tri   [31:0] BUS;

   assign BUS = drv_en ? drv_val : 'z;

   always #5 clk = ~clk;

   disk #(
      .CLKS_PER_BIT (CPB),
      .DEPTH_LOG2   (10)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .RxD       (RxD),
      .TxD       (TxD),
      .BUS       (BUS),
      .Memread   (Memread),
      .Memwrite  (Memwrite),
      .Addrin    (Addrin),
      .debug     (debug),
      .PC        (PC),
      .IR        (IR),
      .Busy      (Busy),
      .Rstate    (Rstate),
      .Tstate    (Tstate),
      .TxD_busy  (TxD_busy),
      .TxD_start (TxD_start)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_start  = 0;
   int          model_ptr = 0;
   logic [7:0]  got_q[$];
   logic [7:0]  exp_q[$];
   logic [31:0] exp_word_q[$];

   always @(negedge clk) if (TxD_start === 1'b1) n_start++;

   // Independent UART receiver on TxD; pushes each framed byte with a good stop bit.
   initial begin : tx_mon
      logic       prev;
      logic [7:0] b;
      prev = 1'b1;
      b    = '0;
      forever begin
         @(negedge clk);
         if (prev === 1'b1 && TxD === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = TxD;
            end
            repeat (CPB) @(negedge clk);
            if (TxD === 1'b1) got_q.push_back(b);
         end
         prev = TxD;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_bit);
      RxD = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         RxD = d[i];
         tick(CPB);
      end
      RxD = stop_bit;
      tick(CPB);
      RxD = 1'b1;
      tick(stop_bit ? CPB : 2 * CPB);
   endtask

   task automatic read_word(input logic [9:0] a, output logic [31:0] v);
      drv_en  = 1'b0;
      Addrin  = a;
      Memread = 1'b1;
      #1;
      v = BUS;
      tick(1);
      Memread = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(3);
      n_checks++; if (TxD !== 1'b1) begin n_fail++; $display("FAIL reset_txd got=%b want=1", TxD); end
      n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", Busy); end
      n_checks++; if (Rstate !== 10'd0) begin n_fail++; $display("FAIL reset_rstate got=%0d want=0", Rstate); end
      n_checks++; if (Tstate !== 16'h0) begin n_fail++; $display("FAIL reset_tstate got=%h want=0000", Tstate); end
      n_checks++; if (TxD_busy !== 1'b0 || TxD_start !== 1'b0) begin
         n_fail++; $display("FAIL reset_txflags got=%b%b want=00", TxD_busy, TxD_start);
      end
      // With Memread low the DUT must not fight an external driver.
      drv_val = 32'h5A5A_A5A5;
      drv_en  = 1'b1;
      #1;
      n_checks++; if (BUS !== 32'h5A5A_A5A5) begin n_fail++; $display("FAIL reset_bus_released got=%h want=5a5aa5a5", BUS); end
      drv_en = 1'b0;
      rst_n  = 1'b1;
      tick(2);
   endtask

   task automatic test_cpu_rw();
      logic [31:0] v;
      logic [9:0]  addrs [2];
      logic [31:0] vals  [2];
      addrs[0] = 10'h005; vals[0] = 32'hDEAD_BEEF;
      addrs[1] = 10'h3FF; vals[1] = 32'h0123_4567;
      for (int i = 0; i < 2; i++) begin
         drv_val  = vals[i];
         drv_en   = 1'b1;
         Addrin   = addrs[i];
         Memwrite = 1'b1;
         tick(1);
         Memwrite = 1'b0;
         drv_en   = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         read_word(addrs[i], v);
         n_checks++; if (v !== vals[i]) begin
            n_fail++; $display("FAIL cpu_rw addr=%h got=%h want=%h", addrs[i], v, vals[i]);
         end
      end
   endtask

   task automatic test_rx_pack();
      logic [31:0] v, e;
      logic [7:0]  bytes [4];
      bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
      exp_word_q.push_back(32'h1234_5678);
      for (int i = 0; i < 4; i++) begin
         send_byte(bytes[i], 1'b1);
         if (i == 2) begin
            n_checks++; if (Rstate !== 10'(model_ptr)) begin
               n_fail++; $display("FAIL rx_partial_rstate got=%0d want=%0d", Rstate, model_ptr);
            end
         end
      end
      model_ptr++;
      tick(2);
      n_checks++; if (Rstate !== 10'(model_ptr)) begin
         n_fail++; $display("FAIL rx_pack_rstate got=%0d want=%0d", Rstate, model_ptr);
      end
      e = exp_word_q.pop_front();
      read_word(10'(model_ptr - 1), v);
      n_checks++; if (v !== e) begin n_fail++; $display("FAIL rx_pack_word got=%h want=%h", v, e); end
   endtask

   task automatic test_framing();
      logic [31:0] v, e;
      logic [7:0]  bytes [4];
      bytes[0] = 8'h9A; bytes[1] = 8'hBC; bytes[2] = 8'hDE; bytes[3] = 8'hF0;
      send_byte(8'hAA, 1'b0);
      n_checks++; if (Rstate !== 10'(model_ptr) || Busy !== 1'b0) begin
         n_fail++; $display("FAIL frame_err got rstate=%0d busy=%b want rstate=%0d busy=0", Rstate, Busy, model_ptr);
      end
      exp_word_q.push_back(32'h9ABC_DEF0);
      for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b1);
      model_ptr++;
      tick(2);
      n_checks++; if (Rstate !== 10'(model_ptr)) begin
         n_fail++; $display("FAIL frame_next_rstate got=%0d want=%0d", Rstate, model_ptr);
      end
      e = exp_word_q.pop_front();
      read_word(10'(model_ptr - 1), v);
      n_checks++; if (v !== e) begin n_fail++; $display("FAIL frame_next_word got=%h want=%h", v, e); end
   endtask

   task automatic test_debug_dump();
      int          s0, k;
      logic [63:0] d;
      logic [7:0]  e, g;
      PC = 32'h0000_0040;
      IR = 32'h2001_0005;
      d  = {PC, IR};
      for (int i = 0; i < 8; i++) exp_q.push_back(d[63 - 8*i -: 8]);
      got_q.delete();
      s0    = n_start;
      debug = 1'b1;
      tick(2);
      debug = 1'b0;
      n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL dump_busy_high got=%b want=1", Busy); end
      k = 0;
      while (Busy === 1'b1 && k < 3000) begin tick(1); k++; end
      n_checks++; if (k >= 3000) begin n_fail++; $display("FAIL dump_done_timeout got=busy want=idle"); end
      tick(4);
      n_checks++; if (n_start - s0 !== 8) begin
         n_fail++; $display("FAIL dump_start_pulses got=%0d want=8", n_start - s0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++; $display("FAIL dump_byte got=none want=%h", e);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin n_fail++; $display("FAIL dump_byte got=%h want=%h", g, e); end
         end
      end
      n_checks++; if (got_q.size() != 0) begin
         n_fail++; $display("FAIL dump_extra_bytes got=%0d want=0", got_q.size());
      end
      n_checks++; if (Tstate[15:12] !== 4'd0 || Tstate[7:0] !== 8'h05) begin
         n_fail++; $display("FAIL dump_tstate got=%h want=0?05", Tstate);
      end
   endtask

   task automatic test_reset_mid_dump();
      int s0, k;
      PC    = 32'h1122_3344;
      IR    = 32'h5566_7788;
      debug = 1'b1;
      tick(2);
      debug = 1'b0;
      k = 0;
      while (Tstate[11:8] !== 4'd3 && k < 2000) begin tick(1); k++; end
      n_checks++; if (k >= 2000) begin n_fail++; $display("FAIL mid_dump_reach_byte3 got=%h want=byte_idx 3", Tstate); end
      tick(20);
      rst_n = 1'b0;
      s0    = n_start;
      tick(1);
      n_checks++; if (TxD !== 1'b1) begin n_fail++; $display("FAIL mid_reset_txd got=%b want=1", TxD); end
      n_checks++; if (Tstate !== 16'h0) begin n_fail++; $display("FAIL mid_reset_tstate got=%h want=0000", Tstate); end
      n_checks++; if (Busy !== 1'b0 || TxD_busy !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_busy got=%b%b want=00", Busy, TxD_busy);
      end
      tick(1);
      rst_n = 1'b1;
      tick(400);
      n_checks++; if (n_start !== s0) begin
         n_fail++; $display("FAIL mid_reset_no_restart got=%0d want=%0d", n_start - s0, 0);
      end
      got_q.delete();
   endtask

   initial begin
      rst_n    = 1'b1;
      RxD      = 1'b1;
      Memread  = 1'b0;
      Memwrite = 1'b0;
      Addrin   = '0;
      debug    = 1'b0;
      PC       = '0;
      IR       = '0;
      drv_val  = '0;
      drv_en   = 1'b0;
      tick(1);
      test_reset();
      test_cpu_rw();
      test_rx_pack();
      test_framing();
      test_debug_dump();
      test_reset_mid_dump();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
